// File: rtl/nes_spi_slave.sv
// SPI mode-0 slave: streams bytes into memory via an auto-incrementing write port and posts controller state.
// Define NES_SPI_RDBACK_EN to enable the STATUS (0x02) read-back command on spi_miso.
module nes_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [7:0]        status_in,
  output logic [7:0]        ctrl_state,
  output logic              ctrl_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        err_count
);

`ifdef NES_SPI_RDBACK_EN
  localparam bit RDBACK_EN = 1'b1;
`else
  localparam bit RDBACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_CTRL_DATA, ST_ADDR_HI,
    ST_ADDR_LO, ST_MEM_DATA, ST_STAT, ST_DISCARD
  } state_e;

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d;
  logic ss_prev_q, ss_prev_d;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  // Bit-level stage
  logic       frame_q, frame_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       byte_done_q, byte_done_d;
  logic       fall_shift_q, fall_shift_d;
  logic       partial_q, partial_d;
  logic       ss_rise_q, ss_rise_d;
  logic       ss_fall_q, ss_fall_d;

  // Byte-level stage
  state_e            state_q, state_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        ctrl_state_q, ctrl_state_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              err_inc;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;

  // The ss_n chain resets low, so a frame interrupted by reset is only
  // re-entered through a fresh high-then-low transition of ss_n.
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d  = sclk_s;
    ss_prev_d    = ss_s;
    frame_d      = frame_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    byte_done_d  = 1'b0;
    fall_shift_d = 1'b0;
    partial_d    = 1'b0;
    ss_rise_d    = ss_rise;
    ss_fall_d    = ss_fall;
    if (ss_fall) begin
      frame_d   = 1'b1;
      bit_cnt_d = 3'd0;
    end else if (frame_q && sclk_rise) begin
      shift_d   = {shift_q[6:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_done_d = 1'b1;
        rx_byte_d   = shift_d;
      end
    end
    // The fall after the 8th rise must not shift out the freshly loaded MSB.
    if (frame_q && sclk_fall && bit_cnt_q != 3'd0) fall_shift_d = 1'b1;
    if (ss_rise) begin
      frame_d   = 1'b0;
      partial_d = frame_q && (bit_cnt_d != 3'd0);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_hi_d    = addr_hi_q;
    tx_d         = tx_q;
    ctrl_state_d = ctrl_state_q;
    ctrl_valid_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_count_d  = err_count_q;
    err_inc      = partial_q;
    if (mem_we_q) mem_addr_d = mem_addr_q + ADDR_W'(1);
    if (RDBACK_EN && fall_shift_q) tx_d = {tx_q[6:0], 1'b0};
    if (byte_done_q) begin
      case (state_q)
        ST_CMD: begin
          case (rx_byte_q)
            8'h01: state_d = ST_CTRL_DATA;
            8'h03: state_d = ST_ADDR_HI;
            8'h02: begin
              if (RDBACK_EN) begin
                state_d = ST_STAT;
                tx_d    = status_in;
              end else begin
                state_d = ST_DISCARD;
                err_inc = 1'b1;
              end
            end
            default: begin
              state_d = ST_DISCARD;
              err_inc = 1'b1;
            end
          endcase
        end
        ST_CTRL_DATA: begin
          ctrl_state_d = rx_byte_q;
          ctrl_valid_d = 1'b1;
        end
        ST_ADDR_HI: begin
          addr_hi_d = rx_byte_q;
          state_d   = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          mem_addr_d = ADDR_W'({addr_hi_q, rx_byte_q});
          state_d    = ST_MEM_DATA;
        end
        ST_MEM_DATA: begin
          mem_we_d    = 1'b1;
          mem_wdata_d = rx_byte_q;
        end
        ST_STAT: tx_d = status_in;
        default: ;
      endcase
    end
    if (err_inc && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    if (ss_rise_q) state_d = ST_IDLE;
    if (ss_fall_q) state_d = ST_CMD;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sync_q  <= '0;
      ss_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      ss_prev_q    <= 1'b0;
      frame_q      <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      byte_done_q  <= 1'b0;
      fall_shift_q <= 1'b0;
      partial_q    <= 1'b0;
      ss_rise_q    <= 1'b0;
      ss_fall_q    <= 1'b0;
      state_q      <= ST_IDLE;
      addr_hi_q    <= 8'h00;
      tx_q         <= 8'h00;
      ctrl_state_q <= 8'h00;
      ctrl_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
      err_count_q  <= 8'h00;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      ss_sync_q    <= ss_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      ss_prev_q    <= ss_prev_d;
      frame_q      <= frame_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      byte_done_q  <= byte_done_d;
      fall_shift_q <= fall_shift_d;
      partial_q    <= partial_d;
      ss_rise_q    <= ss_rise_d;
      ss_fall_q    <= ss_fall_d;
      state_q      <= state_d;
      addr_hi_q    <= addr_hi_d;
      tx_q         <= tx_d;
      ctrl_state_q <= ctrl_state_d;
      ctrl_valid_q <= ctrl_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_count_q  <= err_count_d;
    end
  end

  // mem_we and ctrl_valid are single-cycle strobes; there is no back-pressure.
  assign spi_miso   = RDBACK_EN && (state_q == ST_STAT) && !ss_s && tx_q[7];
  assign ctrl_state = ctrl_state_q;
  assign ctrl_valid = ctrl_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_nes_spi_slave.sv
// Directed bench for nes_spi_slave: memory writes, controller updates, errors, read-back and mid-frame reset.
module tb_nes_spi_slave;
  localparam int ADDR_W = 16;
  localparam int HALF   = 8;

  logic              clk = 1'b0;
  logic              reset_reset;
  logic              spi_sclk, spi_ss_n, spi_mosi, spi_miso;
  logic [7:0]        status_in;
  logic [7:0]        ctrl_state;
  logic              ctrl_valid, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int cv_count = 0;
  int cv_cyc = 0;
  int exp_err = 0;
  int we_base = 0;
  int cv_base = 0;

  logic [ADDR_W+7:0] got_q[$];
  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0]        tx_bytes[$];
  logic [7:0]        rx_bytes[$];

  nes_spi_slave #(.SYNC_STAGES(2), .ADDR_W(ADDR_W)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .status_in(status_in), .ctrl_state(ctrl_state), .ctrl_valid(ctrl_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err_count(err_count)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor
  always @(negedge clk) begin
    if (mem_we) got_q.push_back({mem_addr, mem_wdata});
    if (ctrl_valid) begin
      cv_count = cv_count + 1;
      cv_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] v, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = v[i];
      tick(HALF);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    we_base = got_q.size();
    cv_base = cv_count;
    exp_q.delete();
    rx_bytes.delete();
    spi_ss_n = 1'b0;
    tick(HALF);
  endtask

  task automatic send_bytes();
    logic [7:0] rx;
    foreach (tx_bytes[i]) begin
      send_bits(tx_bytes[i], 8, rx);
      rx_bytes.push_back(rx);
    end
  endtask

  task automatic frame_end();
    tick(HALF);
    spi_ss_n = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, got_q.size() - we_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && we_base + i < got_q.size(); i++)
      check({tag, "_entry"}, got_q[we_base + i], exp_q[i]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, spi_miso, 1'b0);
    check({tag, "_ctrl_state"}, ctrl_state, 8'h00);
    check({tag, "_ctrl_valid"}, ctrl_valid, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 16'h0000);
    check({tag, "_mem_wdata"}, mem_wdata, 8'h00);
    check({tag, "_err_count"}, err_count, 8'h00);
  endtask

  initial begin
    logic [7:0] rx;
    reset_reset = 1'b1;
    spi_sclk = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    status_in = 8'hA5;
    tick(4);
    check_reset_values("rst_hold");
    reset_reset = 1'b0;
    tick(8);
    check_reset_values("rst_idle");

    // streaming memory write
    frame_begin();
    tx_bytes = '{8'h03, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'hCC};
    send_bytes();
    frame_end();
    exp_q = '{{16'h1234, 8'hAA}, {16'h1235, 8'hBB}, {16'h1236, 8'hCC}};
    check_writes("memwr");
    check("memwr_addr_after", mem_addr, 16'h1237);
    check("memwr_err", err_count, 8'd0);

    // address wrap
    frame_begin();
    tx_bytes = '{8'h03, 8'hFF, 8'hFF, 8'h11, 8'h22};
    send_bytes();
    frame_end();
    exp_q = '{{16'hFFFF, 8'h11}, {16'h0000, 8'h22}};
    check_writes("wrap");

    // controller byte with latency
    frame_begin();
    tx_bytes = '{8'h01, 8'h81};
    send_bytes();
    frame_end();
    check("ctrl_state", ctrl_state, 8'h81);
    check("ctrl_pulses", cv_count - cv_base, 1);
    check("ctrl_latency", cv_cyc - last_rise_cyc, 4);
    check("ctrl_no_we", got_q.size() - we_base, 0);

    frame_begin();
    tx_bytes = '{8'h01, 8'h05, 8'h06};
    send_bytes();
    frame_end();
    check("ctrl_multi_state", ctrl_state, 8'h06);
    check("ctrl_multi_pulses", cv_count - cv_base, 2);

    // unknown command
    frame_begin();
    tx_bytes = '{8'h07, 8'h00};
    send_bytes();
    frame_end();
    exp_err = 1;
    check("unk_err", err_count, exp_err);
    check("unk_no_we", got_q.size() - we_base, 0);
    check("unk_no_cv", cv_count - cv_base, 0);
    check("unk_ctrl_kept", ctrl_state, 8'h06);

    // partial data byte
    frame_begin();
    tx_bytes = '{8'h03, 8'h00, 8'h10};
    send_bytes();
    send_bits(8'hE7, 5, rx);
    frame_end();
    exp_err = 2;
    check("partial_no_we", got_q.size() - we_base, 0);
    check("partial_err", err_count, exp_err);

    // status read-back
    frame_begin();
    tx_bytes = '{8'h02, 8'h00, 8'h00};
    send_bytes();
    frame_end();
    check("stat_rx0", rx_bytes[0], 8'h00);
`ifdef NES_SPI_RDBACK_EN
    check("stat_rx1", rx_bytes[1], 8'hA5);
    check("stat_rx2", rx_bytes[2], 8'hA5);
`else
    exp_err = 3;
    check("stat_rx1", rx_bytes[1], 8'h00);
    check("stat_rx2", rx_bytes[2], 8'h00);
`endif
    check("stat_err", err_count, exp_err);
    check("stat_miso_idle", spi_miso, 1'b0);

    // saturation
    for (int n = 0; n < 300; n++) begin
      frame_begin();
      send_bits(8'h5A, 5, rx);
      frame_end();
    end
    check("sat_err", err_count, 8'hFF);

    // reset mid-frame after address bytes
    frame_begin();
    tx_bytes = '{8'h03, 8'h00, 8'h40};
    send_bytes();
    reset_reset = 1'b1;
    tick(2);
    reset_reset = 1'b0;
    tick(1);
    check_reset_values("midrst");
    we_base = got_q.size();
    tx_bytes = '{8'h55, 8'h66};
    send_bytes();
    frame_end();
    check("midrst_no_we", got_q.size() - we_base, 0);
    check("midrst_err", err_count, 8'h00);

    frame_begin();
    tx_bytes = '{8'h03, 8'h00, 8'h40, 8'h77};
    send_bytes();
    frame_end();
    exp_q = '{{16'h0040, 8'h77}};
    check_writes("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
